// File: rtl/lsu_mem_align_pkg.sv
// Shared encodings and legality helpers for the load/store alignment unit.
// RV32I funct3 values, FSM state encoding and request legality rules.
package lsu_mem_align_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RMW_WR = 1'b1
   } state_t;

   // Stores only support the signed encodings; loads also accept BU/HU.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      logic ok;
      ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!we) begin
         ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
      end
      return ok;
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      return (((f3 == F3_H) || (f3 == F3_HU)) && lo[0]) ||
             ((f3 == F3_W) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// Selects the byte/halfword lane of a memory word and sign/zero extends it.
// Words and unknown encodings pass through unchanged.
module lsu_lane_extract
   import lsu_mem_align_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word[7:0];
      case (addr_lo)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = addr_lo[1] ? word[31:16] : word[15:0];

      case (funct3)
         F3_B:    ext = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   ext = {24'h000000, byte_sel};
         F3_H:    ext = {{16{half_sel[15]}}, half_sel};
         F3_HU:   ext = {16'h0000, half_sel};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_align.sv
// Load/store alignment unit in front of a word-only data memory.
// Loads respond one cycle after acceptance; SB/SH use a two-cycle read-modify-write.
module lsu_mem_align
   import lsu_mem_align_pkg::*;
#(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   // Handshake: a request transfers on any rising edge where req_valid and
   // req_ready are both high; req_ready depends only on state, never on req_valid.

   localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

   state_t      state_q, state_d;
   logic [29:0] cap_word_addr_q, cap_word_addr_d;
   logic [31:0] cap_wdata_q, cap_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   logic        accept;
   logic        req_legal;
   logic        is_load;
   logic        is_store_word;
   logic        is_store_part;
   logic [31:0] load_ext;
   logic [31:0] width_mask;
   logic [31:0] lane_mask;
   logic [31:0] wdata_shifted;
   logic [31:0] merged_word;
   logic [4:0]  lane_shift;

   lsu_lane_extract u_load_extract (
      .word    (mem_rd),
      .addr_lo (req_addr[1:0]),
      .funct3  (req_funct3),
      .ext     (load_ext)
   );

   // Zero-extending an all-ones word yields the access width as a mask.
   lsu_lane_extract u_mask_extract (
      .word    (32'hFFFF_FFFF),
      .addr_lo (2'b00),
      .funct3  ({1'b1, req_funct3[1:0]}),
      .ext     (width_mask)
   );

   always_comb begin
      accept        = req_valid && (state_q == ST_IDLE);
      req_legal     = f3_legal(req_we, req_funct3) &&
                      !misaligned(req_funct3, req_addr[1:0]) &&
                      (req_addr < ADDR_LIMIT);
      is_load       = accept && req_legal && !req_we;
      is_store_word = accept && req_legal && req_we && (req_funct3 == F3_W);
      is_store_part = accept && req_legal && req_we && (req_funct3 != F3_W);

      lane_shift    = {req_addr[1:0], 3'b000};
      lane_mask     = width_mask << lane_shift;
      wdata_shifted = req_wdata << lane_shift;
      merged_word   = (mem_rd & ~lane_mask) | (wdata_shifted & lane_mask);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (is_store_part) state_d = ST_RMW_WR;
         ST_RMW_WR: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Reset gates the write strobe so an in-flight RMW is abandoned.
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      mem_we    = 1'b0;
      mem_addr  = {req_addr[31:2], 2'b00};
      mem_wd    = req_wdata;
      case (state_q)
         ST_IDLE: begin
            mem_we = rst_n && is_store_word;
         end
         ST_RMW_WR: begin
            mem_we   = rst_n;
            mem_addr = {cap_word_addr_q, 2'b00};
            mem_wd   = cap_wdata_q;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   always_comb begin
      cap_word_addr_d = is_store_part ? req_addr[31:2] : cap_word_addr_q;
      cap_wdata_d     = is_store_part ? merged_word : cap_wdata_q;
      resp_valid_d    = is_load;
      resp_err_d      = accept && !req_legal;
      resp_rdata_d    = is_load ? load_ext : resp_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cap_word_addr_q <= '0;
         cap_wdata_q     <= '0;
         resp_valid_q    <= 1'b0;
         resp_err_q      <= 1'b0;
         resp_rdata_q    <= '0;
      end else begin
         cap_word_addr_q <= cap_word_addr_d;
         cap_wdata_q     <= cap_wdata_d;
         resp_valid_q    <= resp_valid_d;
         resp_err_q      <= resp_err_d;
         resp_rdata_q    <= resp_rdata_d;
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_align.sv
// Bench for lsu_mem_align: directed steps then random requests, checked
// against a byte-level reference memory and arithmetic load/store rules.
module tb_lsu_mem_align;

   localparam int DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   // clock / memory block
   always #5 clk = ~clk;

   logic [31:0] mem [0:DEPTH-1];
   logic        tb_we = 1'b0;
   logic [5:0]  tb_wa = '0;
   logic [31:0] tb_wd = '0;

   assign mem_rd = mem[mem_addr[7:2]];

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
      else if (tb_we) mem[tb_wa] <= tb_wd;
   end

   lsu_mem_align #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   // reference model
   logic [31:0] ref_mem [0:DEPTH-1];
   int n_checks = 0;
   int n_pass = 0;
   logic        exp_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic [31:0] exp_rdata = '0;

   function automatic int access_bytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit model_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit f3_ok;
      if (we) f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    f3_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!f3_ok) return 0;
      if ((a % access_bytes(f3)) != 0) return 0;
      return a < DEPTH * 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
      int off;
      logic [31:0] v;
      off = int'(a % 4);
      case (f3)
         3'd0: begin v = (w >> (8 * off)) & 32'hFF;   if (v >= 32'h80)   v = v | 32'hFFFF_FF00; end
         3'd4: v = (w >> (8 * off)) & 32'hFF;
         3'd1: begin v = (w >> (8 * off)) & 32'hFFFF; if (v >= 32'h8000) v = v | 32'hFFFF_0000; end
         3'd5: v = (w >> (8 * off)) & 32'hFFFF;
         default: v = w;
      endcase
      return v;
   endfunction

   function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [2:0] f3,
                                               input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      int off;
      off  = int'(a % 4);
      mask = (access_bytes(f3) == 1) ? 32'hFF : 32'hFFFF;
      mask = mask << (8 * off);
      return (w & ~mask) | ((wd << (8 * off)) & mask);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_pending();
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, exp_valid});
      chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      if (exp_valid) chk("resp_rdata", resp_rdata, exp_rdata);
   endtask

   // driver: one request per call; legal SB/SH also consumes the write cycle
   task automatic step(input bit v, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input bit abort_rmw);
      bit legal;
      int idx;
      logic [31:0] merged;
      @(negedge clk);
      check_pending();
      req_valid = v; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      #1;
      legal = model_legal(we, f3, a);
      idx = int'(a[7:2]);
      chk("req_ready", {31'b0, req_ready}, 32'd1);
      chk("mem_addr", mem_addr, {a[31:2], 2'b00});
      chk("mem_we", {31'b0, mem_we}, {31'b0, v && legal && we && (f3 == 3'd2)});
      if (v && legal && we && (f3 == 3'd2)) chk("mem_wd_sw", mem_wd, wd);
      exp_valid = v && legal && !we;
      exp_err   = v && !legal;
      exp_rdata = model_load(ref_mem[idx], f3, a);
      if (v && legal && we && (f3 == 3'd2)) ref_mem[idx] = wd;
      if (v && legal && we && (f3 != 3'd2)) begin
         merged = model_merge(ref_mem[idx], f3, a, wd);
         @(negedge clk);
         check_pending();
         req_valid = 1'b0;
         if (abort_rmw) rst_n = 1'b0;
         #1;
         chk("rmw_ready", {31'b0, req_ready}, 32'd0);
         chk("rmw_addr", mem_addr, {a[31:2], 2'b00});
         if (abort_rmw) begin
            chk("rmw_abort_we", {31'b0, mem_we}, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
            chk("post_rst_valid", {31'b0, resp_valid}, 32'd0);
            chk("post_rst_err", {31'b0, resp_err}, 32'd0);
            chk("post_rst_rdata", resp_rdata, 32'd0);
            chk("post_rst_word", mem[idx], ref_mem[idx]);
         end else begin
            chk("rmw_we", {31'b0, mem_we}, 32'd1);
            chk("rmw_wd", mem_wd, merged);
            ref_mem[idx] = merged;
         end
         exp_valid = 1'b0;
         exp_err   = 1'b0;
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
   endtask

   initial begin
      // reset phase: preload memory through the bench port
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         tb_we = 1'b1;
         tb_wa = 6'(i);
         case (i)
            4:       tb_wd = 32'h1122_3344;
            8:       tb_wd = 32'h80FF_7F01;
            default: tb_wd = $urandom;
         endcase
         ref_mem[i] = tb_wd;
      end
      @(negedge clk);
      tb_we = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h4; req_wdata = 32'hCAFE_F00D;
      #1;
      chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
      @(negedge clk);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_mem_we2", {31'b0, mem_we}, 32'd0);
      req_valid = 1'b0;
      rst_n = 1'b1;
      idle();

      // byte store RMW then read back
      step(1, 1, 3'd0, 32'h11, 32'h0000_00AB, 0);
      step(1, 0, 3'd2, 32'h10, 32'h0, 0);
      // back-to-back lane loads
      step(1, 0, 3'd0, 32'h23, 32'h0, 0);
      step(1, 0, 3'd4, 32'h23, 32'h0, 0);
      step(1, 0, 3'd1, 32'h22, 32'h0, 0);
      step(1, 0, 3'd5, 32'h22, 32'h0, 0);
      step(1, 0, 3'd0, 32'h21, 32'h0, 0);
      // misaligned, illegal funct3, out of range, last word
      step(1, 1, 3'd2, 32'h12, 32'h5555_5555, 0);
      step(1, 0, 3'd1, 32'h21, 32'h0, 0);
      step(1, 0, 3'd3, 32'h0, 32'h0, 0);
      step(1, 0, 3'd2, 32'h100, 32'h0, 0);
      step(1, 0, 3'd2, 32'hFC, 32'h0, 0);
      step(1, 1, 3'd3, 32'h0, 32'h1234_5678, 0);
      // halfword store abandoned by reset in its write cycle
      step(1, 1, 3'd1, 32'h2, 32'h0000_BEEF, 1);
      idle();
      // interleaved SW / SB / LW
      step(1, 1, 3'd2, 32'h8, 32'hDEAD_BEEF, 0);
      step(1, 1, 3'd0, 32'h9, 32'h0000_0000, 0);
      step(1, 0, 3'd2, 32'h8, 32'h0, 0);
      idle();

      // random phase
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a;
         a = 32'($urandom_range(0, 271));
         if ($urandom_range(0, 15) == 0) a = $urandom;
         step(($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              a, $urandom, 0);
      end
      idle();
      idle();

      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("mem_word_%0d", i), mem[i], ref_mem[i]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lsu_mem_align.md
Name: lsu_mem_align

Overview:
- Load/store alignment unit between the EX/MEM pipeline register and the word-only data memory (64 x 32, combinational read, synchronous write).
- Converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
- Byte and halfword stores are done as a two-cycle read-modify-write.
- Load results are returned registered, one cycle after acceptance, with byte-lane select and sign/zero extension. Misaligned and out-of-range accesses are flagged.

Parameters:
- DEPTH, 64, number of 32-bit words in the attached data memory; byte addresses >= DEPTH*4 are out of range.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  load data valid, one-cycle pulse
- resp_rdata  out  32  extended load data
- resp_err  out  1  misaligned / illegal funct3 / out-of-range, one-cycle pulse
- mem_we  out  1  data-memory write enable
- mem_addr  out  32  data-memory byte address, bits [1:0] always 00
- mem_wd  out  32  data-memory write data
- mem_rd  in  32  data-memory read data (combinational on mem_addr)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, capture registers=0.
- While rst_n=0, mem_we is forced 0 combinationally.
- States:
  - IDLE: req_ready=1.
  - RMW_WR: req_ready=0, entered only for a legal SB/SH.
- Accept: req_valid && req_ready. Legality check happens at acceptance:
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores anything other than 000/001/010.
  - Out of range: addr >= DEPTH*4.
  - Any illegal request: no memory write, no resp_valid, resp_err=1 on the next cycle, state stays IDLE.
- mem_addr is {req_addr[31:2],2'b00} in IDLE and {cap_addr[31:2],2'b00} in RMW_WR.
- Legal load, accepted in cycle N:
  - mem_rd is sampled at the end of N.
  - In cycle N+1, resp_valid=1 and resp_rdata = selected lane, extended.
  - B/BU select byte addr[1:0]; H/HU select halfword addr[1]. B/H sign-extend; BU/HU zero-extend; W passes through.
  - Back-to-back loads are accepted every cycle.
- Legal SW: mem_we=1 and mem_wd=req_wdata in the acceptance cycle. No response, stay IDLE.
- Legal SB/SH, accepted in cycle N:
  - Cycle N: mem_we=0. Capture addr, funct3 and wdata. Form the merged word from mem_rd with the target lane replaced by wdata[7:0] or wdata[15:0]. Go to RMW_WR.
  - Cycle N+1: mem_we=1, mem_wd=merged word, req_ready=0. Return to IDLE.
  - The next request is accepted in cycle N+2.
- A store never produces resp_valid. Stores and loads never pulse resp_err when legal.
- Reset asserted during RMW_WR: the write is abandoned (mem_we=0), state goes to IDLE, and the memory word is unchanged.
- req_valid=0 in IDLE: mem_we=0, and no pulses occur on the next cycle.
- All outputs other than req_ready, mem_we, mem_addr and mem_wd are registered.

Decomposition:
- Shared package constants:
  - funct3 encodings F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - State encoding ST_IDLE/ST_RMW_WR.
- One natural combinational sub-module, lsu_lane_extract: takes word, addr[1:0] and funct3 and returns the extended load value. It is reused by the merge logic's lane mask.
- The FSM, capture registers and legality check live in lsu_mem_align.

Test Plan:
- Preload word 0x10 = 0x11223344. SB addr 0x11, wdata 0xAB. Expect req_ready=0 for exactly one cycle, mem_we pulses once with mem_wd=0x1122AB44, and a following LW 0x10 returns 0x1122AB44.
- Preload word 0x20 = 0x80FF7F01. Issue:
  - LB 0x23 -> 0xFFFFFF80
  - LBU 0x23 -> 0x00000080
  - LH 0x22 -> 0xFFFF80FF
  - LHU 0x22 -> 0x000080FF
  - LB 0x21 -> 0x0000007F
  - Each load is issued back-to-back, and each resp_valid arrives exactly one cycle later.
- SW 0x12 and LH 0x21 (misaligned), and funct3 011 load at 0x0 -> resp_err pulses one cycle later each, mem_we never asserts, and memory is unchanged.
- LW 0x100 with DEPTH=64 -> resp_err=1 and resp_valid=0. LW 0xFC -> normal response.
- SH addr 0x2 with wdata 0xBEEF, and rst_n=0 in the RMW_WR cycle -> mem_we=0, word 0x0 is unchanged, and the unit is in IDLE with req_ready=1 after reset.
- Interleaved SW 0x8 = 0xDEADBEEF, SB 0x9 = 0x00, LW 0x8 -> final read 0xDEAD00EF, with no lost or duplicated requests.
